// File: rtl/controller_pkg.sv
// Shared types and defaults for the serial game-pad poller.
// Frame length helper lets the top derive its phase boundaries.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned DEF_NUM_PADS     = 2;
    localparam int unsigned DEF_NUM_BITS     = 16;
    localparam int unsigned DEF_BTN_BITS     = 12;
    localparam int unsigned DEF_CLK_DIV      = 4;
    localparam int unsigned DEF_LATCH_CYCLES = 8;
    localparam int unsigned DEF_POLL_CYCLES  = 4096;

    function automatic int unsigned frame_len(
        input int unsigned clk_div,
        input int unsigned latch_cycles,
        input int unsigned num_bits
    );
        return latch_cycles + clk_div * (2 * num_bits + 1) + 1;
    endfunction

endpackage

// File: rtl/controller_poller_if.sv
// Pad-connector pins and published button bus of the poller.
// CONTROLLER_EDGE_EN adds btn_pressed / btn_released.
interface controller_poller_if
    import controller_pkg::*;
#(
    parameter int unsigned NUM_PADS = DEF_NUM_PADS,
    parameter int unsigned BTN_BITS = DEF_BTN_BITS
);

    logic [NUM_PADS-1:0]          cont_data;
    logic                         cont_clk;
    logic                         cont_activate;
    logic [NUM_PADS*BTN_BITS-1:0] controller_btns;
    logic                         btns_valid;
`ifdef CONTROLLER_EDGE_EN
    logic [NUM_PADS*BTN_BITS-1:0] btn_pressed;
    logic [NUM_PADS*BTN_BITS-1:0] btn_released;

    modport master (
        input  cont_data,
        output cont_clk, cont_activate,
        output controller_btns, btns_valid,
        output btn_pressed, btn_released
    );

    modport slave (
        output cont_data,
        input  cont_clk, cont_activate,
        input  controller_btns, btns_valid,
        input  btn_pressed, btn_released
    );
`else
    modport master (
        input  cont_data,
        output cont_clk, cont_activate,
        output controller_btns, btns_valid
    );

    modport slave (
        output cont_data,
        input  cont_clk, cont_activate,
        input  controller_btns, btns_valid
    );
`endif

endinterface

// File: rtl/controller_sync.sv
// Two-flop synchronizer; resets to all-ones so idle pad lines
// read as released.
module controller_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/controller_poller.sv
// Polls NUM_PADS serial shift-register pads and publishes buttons.
// Optional CONTROLLER_EDGE_EN adds press/release edge strobes.
module controller_poller
    import controller_pkg::*;
#(
    parameter int unsigned NUM_PADS     = DEF_NUM_PADS,
    parameter int unsigned NUM_BITS     = DEF_NUM_BITS,
    parameter int unsigned BTN_BITS     = DEF_BTN_BITS,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int unsigned POLL_CYCLES  = DEF_POLL_CYCLES
) (
    input logic                 clk,
    input logic                 rst,
    controller_poller_if.master bus
);

    localparam int unsigned CNT_W     = $clog2(POLL_CYCLES);
    localparam int unsigned TMR_W     = $clog2(CLK_DIV);
    localparam int unsigned FRAME_LEN =
        frame_len(CLK_DIV, LATCH_CYCLES, NUM_BITS);
    localparam int unsigned BW        = NUM_PADS * BTN_BITS;

    // Frame phases are keyed off the poll counter, which reads f+1.
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_END   = CNT_W'(LATCH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_END   =
        CNT_W'(LATCH_CYCLES + CLK_DIV);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_END   = TMR_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]    cnt_q;
    state_e              state_q;
    logic [TMR_W-1:0]    tmr_q;
    logic                clk_q;
    logic                act_q;
    logic                valid_q;
    logic [BW-1:0]       btns_q;
    logic [BW-1:0]       new_btns;
    logic [NUM_BITS-1:0] sh_q [NUM_PADS];
    logic [NUM_PADS-1:0] sync_data;
    logic [NUM_PADS-1:0] pad_bits;
`ifdef CONTROLLER_EDGE_EN
    logic [BW-1:0]       pressed_q;
    logic [BW-1:0]       released_q;
`endif

    controller_sync #(
        .WIDTH (NUM_PADS)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (bus.cont_data),
        .q_o   (sync_data)
    );

    assign pad_bits = ~sync_data;

    always_comb begin
        new_btns = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            new_btns[p*BTN_BITS +: BTN_BITS] = sh_q[p][BTN_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            clk_q   <= 1'b0;
            act_q   <= 1'b0;
            valid_q <= 1'b0;
            btns_q  <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
                sh_q[p] <= '0;
            end
`ifdef CONTROLLER_EDGE_EN
            pressed_q  <= '0;
            released_q <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef CONTROLLER_EDGE_EN
            pressed_q  <= '0;
            released_q <= '0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (cnt_q == '0) begin
                        state_q <= LATCH;
                        act_q   <= 1'b1;
                        for (int p = 0; p < NUM_PADS; p++) begin
                            sh_q[p] <= '0;
                        end
                    end
                end
                LATCH: begin
                    if (cnt_q == LAT_END) begin
                        state_q <= GAP;
                        act_q   <= 1'b0;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_END) begin
                        state_q <= SHIFT;
                        clk_q   <= 1'b1;
                        tmr_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt_q == FRAME_END) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        btns_q  <= new_btns;
`ifdef CONTROLLER_EDGE_EN
                        pressed_q  <= new_btns & ~btns_q;
                        released_q <= ~new_btns & btns_q;
`endif
                    end else if (tmr_q == TMR_END) begin
                        tmr_q <= '0;
                        clk_q <= ~clk_q;
                        // Sample on the last cycle of the high half.
                        if (clk_q) begin
                            for (int p = 0; p < NUM_PADS; p++) begin
                                sh_q[p] <= {pad_bits[p],
                                            sh_q[p][NUM_BITS-1:1]};
                            end
                        end
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cont_clk        = clk_q;
    assign bus.cont_activate   = act_q;
    assign bus.controller_btns = btns_q;
    assign bus.btns_valid      = valid_q;
`ifdef CONTROLLER_EDGE_EN
    assign bus.btn_pressed     = pressed_q;
    assign bus.btn_released    = released_q;
`endif

endmodule

// File: doc/controller_poller.md
Name: controller_poller

Overview:
- Parametrised serial game-pad reader that polls NUM_PADS shift-register pads.
- The pads share one latch line and one clock line; each pad has its own data line.
- Each frame shifts in NUM_BITS active-low bits per pad and publishes the low BTN_BITS as active-high buttons, with a one-cycle valid strobe.
- Sits between the pad connector pins and the input/MMIO logic, and replaces the fixed single-pad 16-bit reader.

Parameters:
NUM_PADS, 2, number of pads polled in parallel (1..4)
NUM_BITS, 16, serial bits shifted per pad per frame (BTN_BITS..32)
BTN_BITS, 12, low bits published as buttons
CLK_DIV, 4, clk cycles per cont_clk half period (>=4)
LATCH_CYCLES, 8, clk cycles cont_activate is held high (>=2)
POLL_CYCLES, 4096, clk cycles between frame starts; must exceed LATCH_CYCLES+CLK_DIV*(2*NUM_BITS+1)+1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cont_data  in  NUM_PADS  per-pad serial data, active low, asynchronous to clk
cont_clk  out  1  shared pad shift clock, idles low
cont_activate  out  1  shared pad latch, active high
controller_btns  out  NUM_PADS*BTN_BITS  pad p in bits [p*BTN_BITS +: BTN_BITS], 1 = pressed
btns_valid  out  1  one-cycle pulse when controller_btns updates

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - cont_clk = 0, cont_activate = 0, controller_btns = 0, btns_valid = 0.
  - Poll counter = 0, state = IDLE, shift registers = 0.
- Input sync: each cont_data bit passes through a 2-flop synchronizer, then is inverted before shifting.
- Poll counter:
  - Free-running, 0..POLL_CYCLES-1, then wraps.
  - A frame starts on the cycle the counter reads 0.
  - The first frame after reset deasserts therefore starts immediately.
- FSM, with frame cycle f = 0 at frame start:
  - IDLE: all outputs idle. Go to LATCH when the counter reads 0.
  - LATCH: cont_activate = 1 for f = 0..LATCH_CYCLES-1.
  - GAP: cont_clk = 0 for CLK_DIV cycles.
  - SHIFT, bit k = 0..NUM_BITS-1:
    - cont_clk = 1 for CLK_DIV cycles, then 0 for CLK_DIV cycles.
    - The synchronized, inverted data of every pad is sampled on the last cycle of the high half.
    - Samples shift in at the MSB and move right, so the first bit received lands in bit 0.
  - DONE: one cycle. Load controller_btns with the low BTN_BITS of each shift register and pulse btns_valid. Then go to IDLE.
  - Bits BTN_BITS..NUM_BITS-1 are shifted and discarded.
- Timing with defaults:
  - Bit k is sampled at f = 15+8k.
  - Last sample is at f = 135.
  - btns_valid is high at f = 140 only.
  - controller_btns holds its value until the next DONE.
- Pad model contract: the pad presents bit 0 when cont_activate falls, and advances on each falling edge of cont_clk.
- Shift registers clear on entry to LATCH; there is no carry-over between frames.
- Reset mid-frame: abort immediately and return to the reset values. No partial result is published.
- Counter wrap while not in IDLE: cannot occur under the POLL_CYCLES constraint; no recovery logic.
- A data line stuck high (no pad attached) reads as all buttons released.

Optional Feature:
- Macro: CONTROLLER_EDGE_EN.
- When defined, two extra ports exist:
  - btn_pressed out NUM_PADS*BTN_BITS
  - btn_released out NUM_PADS*BTN_BITS
- Both are valid only in the btns_valid cycle and 0 otherwise:
  - btn_pressed = new & ~old.
  - btn_released = ~new & old.
  - old is the previous controller_btns; it is 0 after reset.
- When not defined, these ports and the old-value logic are absent. All other behaviour is identical.

Decomposition:
- Package controller_pkg holds:
  - the FSM state enum (IDLE, LATCH, GAP, SHIFT, DONE);
  - default parameter constants;
  - a localparam function computing frame length from CLK_DIV, LATCH_CYCLES and NUM_BITS.
- Sub-module controller_sync: a 2-flop synchronizer with WIDTH parameter, reset to 1 (released). It is instantiated once with WIDTH = NUM_PADS.

Test Plan:
- Reset release, defaults:
  - cont_activate is high at f = 0..7.
  - The first cont_clk rise is at f = 12.
  - Exactly 16 cont_clk pulses, each 4 high / 4 low.
  - btns_valid is high only at f = 140.
  - The next frame starts at f = 4096.
- Pad 0 drives pattern 16'hF5A3 and pad 1 drives 16'hFFFF (active-low lines, bit 0 first):
  - controller_btns[11:0] = 12'hA5C.
  - controller_btns[23:12] = 12'h000.
- NUM_PADS=3, NUM_BITS=24, BTN_BITS=16, CLK_DIV=6: pads drive distinct patterns → 24 cont_clk pulses, and each pad's low 16 bits are published correctly.
- Assert rst at f = 60 mid-SHIFT: all outputs are 0 on the next cycle, no btns_valid that frame, and a clean frame starts at the counter restart.
- Bench pad changes data on the rising edge of cont_clk instead of the falling edge: verify samples are still taken at end-of-high. Document the mismatch as a failing contract check.
- CONTROLLER_EDGE_EN, pad 0 bit 3 pressed in frame 1 and released in frame 3:
  - btn_pressed[3] pulses in frame 1 only.
  - btn_released[3] pulses in frame 3 only.
  - Both are 0 in frame 2.
